// File: rtl/dma_mem_port.sv
// Word-memory port: queues DMA word requests in a small FIFO and arbitrates them against
// CPU loads/stores onto one single-port synchronous RAM; read data returns one cycle after grant.
module dma_mem_port #(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int HI_WM      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_en,
  input  logic        dma_wr_en,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_valid,
  output logic        dma_ovf,
  input  logic        cpu_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_valid,
  output logic        cpu_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_DMA = 2'd1,
    GNT_CPU = 2'd2
  } state_t;

  req_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  req_t          head;
  logic          fifo_empty, fifo_full, push, pop;

  // state_nxt is this cycle's grant; state remembers it so the read result can be routed
  state_t        state, state_nxt;
  logic          last_rd;

  logic [31:0]   ram [DEPTH];
  logic [31:0]   ram_q;
  logic          acc_en, acc_wr;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic [31:0]   dma_hold, cpu_hold;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{dma_addr[31:2+AW], dma_addr[1:0], cpu_addr[31:2+AW], cpu_addr[1:0]};

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = (state_nxt == GNT_DMA);
  // A full FIFO still accepts a push in the cycle it pops
  assign push       = dma_en & (~fifo_full | pop);

  always_comb begin
    state_nxt = IDLE;
    acc_en    = 1'b0;
    acc_wr    = 1'b0;
    acc_idx   = '0;
    acc_wdata = '0;
    if (!fifo_empty && (32'(count) >= HI_WM || !cpu_en)) begin
      state_nxt = GNT_DMA;
      acc_en    = 1'b1;
      acc_wr    = head.wr;
      acc_idx   = head.idx;
      acc_wdata = head.wdata;
    end else if (cpu_en) begin
      state_nxt = GNT_CPU;
      acc_en    = 1'b1;
      acc_wr    = cpu_wr_en;
      acc_idx   = cpu_addr[2 +: AW];
      acc_wdata = cpu_wdata;
    end
    cpu_stall = cpu_en & (state_nxt != GNT_CPU);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dma_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (dma_en && !push) dma_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{wr: dma_wr_en, idx: dma_addr[2 +: AW], wdata: dma_wdata};
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_wr)  ram[acc_idx] <= acc_wdata;
    if (acc_en && !acc_wr) ram_q <= ram[acc_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_rd  <= 1'b0;
      dma_hold <= '0;
      cpu_hold <= '0;
    end else begin
      state   <= state_nxt;
      last_rd <= acc_en & ~acc_wr;
      if (dma_valid) dma_hold <= ram_q;
      if (cpu_valid) cpu_hold <= ram_q;
    end
  end

  assign dma_valid = (state == GNT_DMA) && last_rd;
  assign cpu_valid = (state == GNT_CPU) && last_rd;
  assign dma_rdata = dma_valid ? ram_q : dma_hold;
  assign cpu_rdata = cpu_valid ? ram_q : cpu_hold;

endmodule

// File: tb/tb_dma_mem_port.sv
// Randomized scoreboard bench for dma_mem_port against a queue/array reference model.
module tb_dma_mem_port;
  localparam int FD    = 4;
  localparam int HI_WM = 3;
  localparam int AW    = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n = 1'b0;
  logic        dma_en = 0, dma_wr_en = 0, cpu_en = 0, cpu_wr_en = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0, cpu_addr = 0, cpu_wdata = 0;
  logic [31:0] dma_rdata, cpu_rdata;
  logic        dma_valid, dma_ovf, cpu_valid, cpu_stall;

  logic        rst_n_b = 1'b0;
  logic        dma_en_b = 0, dma_wr_en_b = 0, cpu_en_b = 0, cpu_wr_en_b = 0;
  logic [31:0] dma_addr_b = 0, dma_wdata_b = 0, cpu_addr_b = 0, cpu_wdata_b = 0;
  logic [31:0] dma_rdata_b, cpu_rdata_b;
  logic        dma_valid_b, dma_ovf_b, cpu_valid_b, cpu_stall_b;

  dma_mem_port u_dut (
    .clk(clk), .rst_n(rst_n),
    .dma_en(dma_en), .dma_wr_en(dma_wr_en), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_valid(dma_valid), .dma_ovf(dma_ovf),
    .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_stall(cpu_stall)
  );

  // High-watermark above FIFO capacity so the CPU always wins and the FIFO can fill
  dma_mem_port #(.DEPTH(64), .FIFO_DEPTH(4), .HI_WM(5)) u_ovf (
    .clk(clk), .rst_n(rst_n_b),
    .dma_en(dma_en_b), .dma_wr_en(dma_wr_en_b), .dma_addr(dma_addr_b), .dma_wdata(dma_wdata_b),
    .dma_rdata(dma_rdata_b), .dma_valid(dma_valid_b), .dma_ovf(dma_ovf_b),
    .cpu_en(cpu_en_b), .cpu_wr_en(cpu_wr_en_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_rdata(cpu_rdata_b), .cpu_valid(cpu_valid_b), .cpu_stall(cpu_stall_b)
  );

  typedef struct { bit wr; int idx; logic [31:0] d; } mreq_t;
  typedef struct { logic [31:0] d; bit known; int cyc; } exp_t;
  mreq_t       mq[$];
  logic [31:0] mmem[int];
  exp_t        dexp[$], cexp[$];
  bit          movf = 0;
  int          tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t lookup(input int idx, input int c);
    exp_t e;
    e.known = mmem.exists(idx);
    e.d     = e.known ? mmem[idx] : 32'h0;
    e.cyc   = c;
    return e;
  endfunction

  // One clock cycle: drive inputs, predict grant from the spec's priority rule, update model.
  task automatic step(input bit de, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                      input bit ce, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      output bit cdone);
    bit gd, gc;
    mreq_t r;
    int cidx;
    #1;
    dma_en = de; dma_wr_en = dw; dma_addr = da; dma_wdata = dd;
    cpu_en = ce; cpu_wr_en = cw; cpu_addr = ca; cpu_wdata = cd;
    gd = (mq.size() > 0) && (mq.size() >= HI_WM || !ce);
    gc = !gd && ce;
    #1;
    check("cpu_stall", 32'(cpu_stall), 32'(ce && !gc));
    if (gd) begin
      r = mq.pop_front();
      if (r.wr) mmem[r.idx] = r.d;
      else dexp.push_back(lookup(r.idx, cyc + 1));
    end
    if (gc) begin
      cidx = int'(ca[2 +: AW]);
      if (cw) mmem[cidx] = cd;
      else cexp.push_back(lookup(cidx, cyc + 1));
    end
    if (de) begin
      if (mq.size() < FD) begin
        r.wr = dw; r.idx = int'(da[2 +: AW]); r.d = dd;
        mq.push_back(r);
      end else movf = 1;
    end
    cdone = gc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 0;
    dma_en = 0; dma_wr_en = 0; cpu_en = 0; cpu_wr_en = 0;
    mq.delete(); dexp.delete(); cexp.delete(); movf = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_dma_valid", 32'(dma_valid), 0);
    check("rst_cpu_valid", 32'(cpu_valid), 0);
    check("rst_dma_ovf", 32'(dma_ovf), 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    rst_n = 1;
    @(posedge clk);
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // Scoreboard monitor: pops the expected response whenever a valid pulse appears
  exp_t        me;
  logic [31:0] dlast = 0, clast = 0;
  bit          dok = 1, cok = 1;
  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      dlast = 0; clast = 0; dok = 1; cok = 1;
    end else begin
      if (dma_valid) begin
        if (dexp.size() == 0) begin
          tests++; fails++;
          $display("FAIL dma_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          me = dexp.pop_front();
          check("dma_latency", 32'(cyc), 32'(me.cyc));
          if (me.known) begin check("dma_rdata", dma_rdata, me.d); dlast = me.d; dok = 1; end
          else dok = 0;
        end
      end else begin
        if (dexp.size() > 0 && dexp[0].cyc <= cyc) begin
          me = dexp.pop_front();
          tests++; fails++;
          $display("FAIL dma_valid_missing: got 0 expected 1 (cycle %0d)", cyc);
        end
        if (dok) check("dma_rdata_hold", dma_rdata, dlast);
      end
      if (cpu_valid) begin
        if (cexp.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          me = cexp.pop_front();
          check("cpu_latency", 32'(cyc), 32'(me.cyc));
          if (me.known) begin check("cpu_rdata", cpu_rdata, me.d); clast = me.d; cok = 1; end
          else cok = 0;
        end
      end else begin
        if (cexp.size() > 0 && cexp[0].cyc <= cyc) begin
          me = cexp.pop_front();
          tests++; fails++;
          $display("FAIL cpu_valid_missing: got 0 expected 1 (cycle %0d)", cyc);
        end
        if (cok) check("cpu_rdata_hold", cpu_rdata, clast);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d, cpend, cw;
    logic [31:0] ca, cd;
    int rate;

    do_reset();

    // DMA write then read back of the same word, CPU idle
    step(1, 1, 32'h5000, 32'hDEAD_BEEF, 0, 0, 0, 0, d);
    idle(3);
    check("t1_ovf", 32'(dma_ovf), 0);
    step(1, 0, 32'h5000, 0, 0, 0, 0, 0, d);
    idle(3);

    // CPU load with one DMA request queued: CPU first, then DMA
    step(0, 0, 0, 0, 1, 1, 32'h10, 32'h1234_5678, d);
    step(1, 0, 32'h5000, 0, 0, 0, 0, 0, d);
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, d);
    check("t3_cpu_first", 32'(d), 1);
    idle(3);

    // 16-word DMA write burst while the CPU keeps issuing loads
    for (int i = 0; i < 16; i++)
      step(1, 1, 32'h5000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1, 0, 32'h10, 0, d);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, 32'h10, 0, d);
    idle(2);
    check("t4_ovf", 32'(dma_ovf), 0);
    for (int i = 0; i < 16; i++) step(1, 0, 32'h5000 + 32'(4 * i), 0, 0, 0, 0, 0, d);
    idle(4);

    // Random traffic with varying DMA burst density and aliased addresses
    cpend = 0; cw = 0; ca = 0; cd = 0;
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 3 == 0) ? 2 : ((i / 500) % 3 == 1) ? 5 : 9;
      if (!cpend && $urandom_range(0, 9) < 4) begin
        cpend = 1; cw = 1'($urandom_range(0, 1)); ca = raddr(); cd = $urandom;
      end
      step($urandom_range(0, 9) < rate, 1'($urandom_range(0, 1)), raddr(), $urandom,
           cpend, cw, ca, cd, d);
      if (d) cpend = 0;
    end
    idle(8);
    check("rand_ovf", 32'(dma_ovf), 32'(movf));

    // Reset with three DMA reads queued behind CPU traffic
    step(1, 0, 32'h5000, 0, 1, 0, 32'h14, 0, d);
    step(1, 0, 32'h5004, 0, 1, 0, 32'h14, 0, d);
    step(1, 0, 32'h5008, 0, 1, 0, 32'h14, 0, d);
    do_reset();
    idle(3);
    step(0, 0, 0, 0, 1, 0, 32'h8, 0, d);
    check("t6_fifo_empty", 32'(d), 1);
    step(1, 0, 32'h5000, 0, 0, 0, 0, 0, d);
    step(1, 0, 32'h5004, 0, 0, 0, 0, 0, d);
    idle(4);

    // Overflow on the high-watermark-5 instance
    #1 rst_n_b = 1;
    @(posedge clk);
    check("t5_ovf_init", 32'(dma_ovf_b), 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      dma_en_b = 1; dma_wr_en_b = 1; dma_addr_b = 32'(4 * i); dma_wdata_b = 32'(i);
      cpu_en_b = 1; cpu_wr_en_b = 0; cpu_addr_b = 0;
      #1 check("t5_stall", 32'(cpu_stall_b), 0);
      @(posedge clk);
      #1 check("t5_ovf", 32'(dma_ovf_b), 32'(i >= 4));
    end
    dma_en_b = 0; cpu_en_b = 0;
    repeat (5) @(posedge clk);
    #1 check("t5_ovf_sticky", 32'(dma_ovf_b), 1);
    rst_n_b = 0;
    #1 check("t5_ovf_reset", 32'(dma_ovf_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
